// File: rtl/cpu161_pkg.sv
// Shared definitions for the hc161-driven fetch sequencer: FSM state
// encodings and the 4-bit opcode map.
package cpu161_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  // Opcodes 8..F are reserved.
  function automatic logic is_reserved(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu4.sv
// 4-bit add/subtract. For subtract, c is the borrow (a < b).
module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] y,
  output logic       c
);

  // 5-bit arithmetic: bit 4 is carry-out on add, borrow on subtract.
  always_comb begin
    if (sub) {c, y} = {1'b0, a} - {1'b0, b};
    else     {c, y} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/fetch_seq.sv
// Two-cycle fetch/execute sequencer steering an external hc161 program
// counter. FETCH latches the ROM word at Qn; EXEC drives the counter's
// load/count controls and updates ACC/CARRY on the edge that ends it.
module fetch_seq
  import cpu161_pkg::*;
#(
  parameter bit WRAP_HALT = 1'b0
) (
  input  logic       CP,
  input  logic       MRN,
  input  logic       RUN,
  input  logic [3:0] Qn,
  input  logic       TC,
  input  logic [7:0] INSTR,
  output logic       CEP,
  output logic       CET,
  output logic       PEN,
  output logic [3:0] Dn,
  output logic [3:0] ACC,
  output logic       CARRY,
  output logic       HALT,
  output logic       ILLEGAL,
  output logic [1:0] STATE
);

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [3:0] op, imm;
  logic       in_exec, jmp_taken, do_count, wrap;
  logic [3:0] alu_y;
  logic       alu_c;

  assign op  = ir[7:4];
  assign imm = ir[3:0];

  alu4 u_alu (
    .a  (ACC),
    .b  (imm),
    .sub(op == OP_SUB),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Flags are only written at the end of EXEC, so during EXEC they still
  // hold their entry values, which is what JZ/JC must test.
  assign in_exec   = (state == ST_EXEC);
  assign jmp_taken = in_exec && ((op == OP_JMP) ||
                                 (op == OP_JZ && ACC == 4'h0) ||
                                 (op == OP_JC && CARRY));
  assign do_count  = in_exec && !jmp_taken && (op != OP_HALT);
  assign wrap      = do_count && TC && (Qn == 4'hF);

  // State register.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and hc161 control; counter holds outside EXEC.
  always_comb begin
    state_nxt = state;
    PEN       = 1'b1;
    CEP       = 1'b0;
    CET       = 1'b0;
    Dn        = 4'h0;
    ILLEGAL   = 1'b0;
    case (state)
      ST_IDLE:  if (RUN) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        ILLEGAL = is_reserved(op);
        if (jmp_taken) begin
          PEN = 1'b0;
          Dn  = imm;
        end
        CEP = do_count;
        CET = do_count;
        if (op == OP_HALT || (WRAP_HALT && wrap)) state_nxt = ST_HALTED;
        else if (RUN)                             state_nxt = ST_FETCH;
        else                                      state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_HALTED;
    endcase
  end

  // Instruction register, loaded with the word addressed by Qn in FETCH.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN)                  ir <= 8'h00;
    else if (state == ST_FETCH) ir <= INSTR;
  end

  // Accumulator and carry, written on the edge that ends EXEC.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      ACC   <= 4'h0;
      CARRY <= 1'b0;
    end else if (in_exec) begin
      case (op)
        OP_LDA:         ACC <= imm;
        OP_ADD, OP_SUB: {CARRY, ACC} <= {alu_c, alu_y};
        default: ;
      endcase
    end
  end

  assign HALT  = (state == ST_HALTED);
  assign STATE = state;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench: fetch_seq driving an hc161 counter model and a 16x8 ROM.
// A second instance with WRAP_HALT=1 runs an all-NOP program alongside.
module tb_fetch_seq;
  import cpu161_pkg::*;

  logic       cp = 1'b0, mrn = 1'b0, run = 1'b0, run_w = 1'b0;
  logic [3:0] qn, dn, acc;
  logic       tc, cep, cet, pen, carry, halt, illegal;
  logic [1:0] state;
  logic [7:0] instr;
  logic [7:0] rom [16];

  logic [3:0] qn_w, dn_w, acc_w;
  logic       tc_w, cep_w, cet_w, pen_w, carry_w, halt_w, illegal_w;
  logic [1:0] state_w;

  int checks = 0, failures = 0;

  always #5 cp = ~cp;

  assign instr = rom[qn];

  fetch_seq #(.WRAP_HALT(1'b0)) dut (
    .CP(cp), .MRN(mrn), .RUN(run), .Qn(qn), .TC(tc), .INSTR(instr),
    .CEP(cep), .CET(cet), .PEN(pen), .Dn(dn), .ACC(acc), .CARRY(carry),
    .HALT(halt), .ILLEGAL(illegal), .STATE(state)
  );

  fetch_seq #(.WRAP_HALT(1'b1)) dut_w (
    .CP(cp), .MRN(mrn), .RUN(run_w), .Qn(qn_w), .TC(tc_w), .INSTR(8'h00),
    .CEP(cep_w), .CET(cet_w), .PEN(pen_w), .Dn(dn_w), .ACC(acc_w), .CARRY(carry_w),
    .HALT(halt_w), .ILLEGAL(illegal_w), .STATE(state_w)
  );

  // hc161 models: async clear, sync parallel load (PE low), count on CEP&CET.
  always_ff @(posedge cp or negedge mrn) begin
    if (!mrn)            qn <= 4'h0;
    else if (!pen)       qn <= dn;
    else if (cep && cet) qn <= qn + 4'h1;
  end
  assign tc = (&qn) & cet;

  always_ff @(posedge cp or negedge mrn) begin
    if (!mrn)                qn_w <= 4'h0;
    else if (!pen_w)         qn_w <= dn_w;
    else if (cep_w && cet_w) qn_w <= qn_w + 4'h1;
  end
  assign tc_w = (&qn_w) & cet_w;

  typedef struct {
    logic [15:0][7:0] prog;
    logic [3:0]       acc;
    logic             carry;
    logic [3:0]       qn;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  vec_t sb [$];
  vec_t e;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0][7:0] p);
    for (int i = 0; i < 16; i++) rom[i] = p[i];
  endtask

  task automatic do_reset();
    run = 1'b0;
    run_w = 1'b0;
    mrn = 1'b0;
    repeat (2) @(negedge cp);
    mrn = 1'b1;
  endtask

  task automatic wait_halt(input int max, output int cyc);
    cyc = 0;
    while (!halt && cyc < max) begin
      @(negedge cp);
      cyc++;
    end
  endtask

  int cyc;
  logic hw_prev;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // {program, ACC, CARRY, final Qn}; every program ends on a HALT op.
    for (int k = 0; k < NV; k++) vecs[k].prog = '0;
    vecs[0].prog[0] = 8'h13; vecs[0].prog[1] = 8'h25; vecs[0].prog[2] = 8'h70;
    vecs[0].acc = 4'h8; vecs[0].carry = 1'b0; vecs[0].qn = 4'd2;
    vecs[1].prog[0] = 8'h1F; vecs[1].prog[1] = 8'h22; vecs[1].prog[2] = 8'h63;
    vecs[1].prog[3] = 8'h70; vecs[1].prog[4] = 8'h70;
    vecs[1].acc = 4'h1; vecs[1].carry = 1'b1; vecs[1].qn = 4'd3;
    // JZ taken (ACC=0) to 4, then SUB borrows and JZ falls through to HALT.
    vecs[2].prog[0] = 8'h12; vecs[2].prog[1] = 8'h32; vecs[2].prog[2] = 8'h54;
    vecs[2].prog[3] = 8'h70; vecs[2].prog[4] = 8'h33; vecs[2].prog[5] = 8'h53;
    vecs[2].prog[6] = 8'h70;
    vecs[2].acc = 4'hD; vecs[2].carry = 1'b1; vecs[2].qn = 4'd6;
    vecs[3].prog[0] = 8'h10; vecs[3].prog[1] = 8'h31; vecs[3].prog[2] = 8'h70;
    vecs[3].acc = 4'hF; vecs[3].carry = 1'b1; vecs[3].qn = 4'd2;
    // ADD overflows to 0 with carry; LDA then leaves CARRY alone.
    vecs[4].prog[0] = 8'h1F; vecs[4].prog[1] = 8'h21; vecs[4].prog[2] = 8'h13;
    vecs[4].prog[3] = 8'h70;
    vecs[4].acc = 4'h3; vecs[4].carry = 1'b1; vecs[4].qn = 4'd3;
    vecs[5].prog[0] = 8'h15; vecs[5].prog[1] = 8'h62; vecs[5].prog[2] = 8'h70;
    vecs[5].acc = 4'h5; vecs[5].carry = 1'b0; vecs[5].qn = 4'd2;
    vecs[6].prog[0] = 8'h17; vecs[6].prog[1] = 8'h48; vecs[6].prog[8] = 8'h70;
    vecs[6].acc = 4'h7; vecs[6].carry = 1'b0; vecs[6].qn = 4'd8;

    // Reset state while MRN is held low.
    #1;
    chk("rst_state", state, 0);  chk("rst_acc", acc, 0);
    chk("rst_carry", carry, 0);  chk("rst_halt", halt, 0);
    chk("rst_illegal", illegal, 0); chk("rst_pen", pen, 1);
    chk("rst_cep", cep, 0);      chk("rst_cet", cet, 0);
    chk("rst_dn", dn, 0);        chk("rst_qn", qn, 0);

    // Timing: FETCH entry on first RUN edge, 3 instructions = 6 cycles.
    load_rom(vecs[0].prog);
    do_reset();
    @(negedge cp);
    chk("idle_no_run", state, 0);
    run = 1'b1;
    @(negedge cp);
    chk("fetch_state", state, 1); chk("fetch_pen", pen, 1);
    chk("fetch_cep", cep, 0);     chk("fetch_dn", dn, 0);
    wait_halt(50, cyc);
    chk("halt_cycles", cyc, 6);

    // Table-driven programs, expected results queued at launch.
    for (int k = 0; k < NV; k++) begin
      load_rom(vecs[k].prog);
      do_reset();
      sb.push_back(vecs[k]);
      run = 1'b1;
      wait_halt(200, cyc);
      chk($sformatf("v%0d_halted", k), halt, 1);
      e = sb.pop_front();
      chk($sformatf("v%0d_acc", k), acc, e.acc);
      chk($sformatf("v%0d_carry", k), carry, e.carry);
      chk($sformatf("v%0d_qn", k), qn, e.qn);
      chk($sformatf("v%0d_state", k), state, 3);
      repeat (3) @(negedge cp);
      chk($sformatf("v%0d_hold_acc", k), acc, e.acc);
      chk($sformatf("v%0d_hold_state", k), state, 3);
    end

    // All-NOP wrap: both instances start together.
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    do_reset();
    run = 1'b1;
    run_w = 1'b1;
    @(negedge cp);
    cyc = 0;
    hw_prev = 1'b0;
    do begin
      hw_prev = halt_w;
      @(negedge cp);
      cyc++;
    end while (!(qn == 4'h0 && cyc > 2) && cyc < 40);
    chk("wrap_cycles", cyc, 32);
    chk("wrap_main_state", state, 1);
    chk("wrap_main_halt", halt, 0);
    chk("wh_halt", halt_w, 1);
    chk("wh_halt_prev", hw_prev, 0);
    chk("wh_qn", qn_w, 0);
    chk("wh_state", state_w, 3);
    chk("wh_illegal", illegal_w, 0);
    chk("wh_acc", acc_w, 0);
    chk("wh_carry", carry_w, 0);
    repeat (2) @(negedge cp);
    chk("wrap_continue_qn", qn, 1);

    // Reserved opcode at address 0.
    rom[0] = 8'h9A; rom[1] = 8'h70;
    do_reset();
    run = 1'b1;
    @(negedge cp);
    chk("ill_fetch", illegal, 0);
    @(negedge cp);
    chk("ill_pulse", illegal, 1);
    chk("ill_cep", cep, 1);
    chk("ill_pen", pen, 1);
    @(negedge cp);
    chk("ill_drop", illegal, 0);
    chk("ill_qn", qn, 1);
    chk("ill_acc", acc, 0);

    // Jump to the current address, then RUN dropped during FETCH.
    rom[0] = 8'h00; rom[1] = 8'h41;
    do_reset();
    run = 1'b1;
    repeat (4) @(negedge cp);
    chk("self_state", state, 2); chk("self_pen", pen, 0);
    chk("self_dn", dn, 1);       chk("self_qn", qn, 1);
    chk("self_cep", cep, 0);
    repeat (2) @(negedge cp);
    chk("self_qn2", qn, 1);
    @(negedge cp);
    chk("drop_fetch", state, 1);
    run = 1'b0;
    @(negedge cp);
    chk("drop_exec", state, 2);
    @(negedge cp);
    chk("drop_idle", state, 0);
    chk("drop_qn", qn, 1);

    // Reset mid-EXEC of ADD.
    load_rom(vecs[0].prog);
    do_reset();
    run = 1'b1;
    repeat (4) @(negedge cp);
    chk("mid_state", state, 2);
    chk("mid_acc", acc, 3);
    run = 1'b0;
    mrn = 1'b0;
    #1;
    chk("mid_rst_acc", acc, 0);  chk("mid_rst_state", state, 0);
    chk("mid_rst_qn", qn, 0);    chk("mid_rst_pen", pen, 1);
    @(negedge cp);
    mrn = 1'b1;
    @(negedge cp);
    chk("mid_idle", state, 0);
    run = 1'b1;
    wait_halt(50, cyc);
    chk("mid_restart_acc", acc, 8);
    chk("mid_restart_qn", qn, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
